// File: rtl/fp_result_queue.sv
// rtl/fp_result_queue.sv - in-order FP result/flags FIFO with sticky exception flags
module fp_result_queue #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic [4:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 37;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             push, pop;

  // Full/empty come from the occupancy count only, so in_ready never sees out_ready.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign {out_result, out_flags} = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign fflags = fflags_q;

  // Occupancy and sticky-flag next state; popped flags survive a same-cycle clear.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (pop ? out_flags : 5'b0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  // Entry storage, written only on push and cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {in_result, in_flags};
    end
  end

endmodule

// File: tb/tb_fp_result_queue.sv
// tb/tb_fp_result_queue.sv - self-checking bench for fp_result_queue
module tb_fp_result_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int ST_W  = CNT_W + 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_result = '0;
  logic [4:0]       in_flags = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [4:0]       out_flags;
  logic [4:0]       fflags;
  logic             fflags_clr = 1'b0;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int failures = 0;

  // Reference model: an in-order list of entries plus the sticky flag word.
  logic [36:0] mq [$];
  logic [4:0]  mf = '0;

  logic [ST_W-1:0] dut_state;
  logic [36:0]     dut_head;
  assign dut_state = {count, in_ready, out_valid, fflags};
  assign dut_head  = {out_result, out_flags};

  always #5 clk = ~clk;

  fp_result_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .fflags(fflags), .fflags_clr(fflags_clr), .count(count)
  );

  function automatic logic [ST_W-1:0] exp_state();
    return {CNT_W'(mq.size()), mq.size() != DEPTH, mq.size() != 0, mf};
  endfunction

  // Drive one cycle of inputs, advance the model by the queue rules, return whether a push happened.
  task automatic drive_cycle(input logic v, input logic r, input logic c,
                             input logic [31:0] res, input logic [4:0] fl, output logic acc);
    logic m_push, m_pop;
    logic [4:0] nf;
    @(negedge clk);
    in_valid = v; out_ready = r; fflags_clr = c; in_result = res; in_flags = fl;
    #1;
    m_push = v && (mq.size() < DEPTH);
    m_pop  = r && (mq.size() > 0);
    nf = (c ? 5'b0 : mf) | (m_pop ? mq[0][4:0] : 5'b0);
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back({res, fl});
    mf = nf;
    acc = m_push;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); mf = '0;
    #1;
    checks++;
    if (dut_state !== {3'd0, 1'b1, 1'b0, 5'd0}) begin
      failures++; $display("FAIL reset_state got=%h want=%h", dut_state, {3'd0, 1'b1, 1'b0, 5'd0});
    end
    checks++;
    if (dut_head !== 37'd0) begin
      failures++; $display("FAIL reset_head got=%h want=0", dut_head);
    end
  endtask

  task automatic test_single();
    logic acc;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h3F800000, 5'b00000, acc);
    checks++;
    if (dut_state !== {3'd1, 1'b1, 1'b1, 5'd0}) begin
      failures++; $display("FAIL single_state got=%h want=%h", dut_state, {3'd1, 1'b1, 1'b1, 5'd0});
    end
    checks++;
    if (dut_head !== {32'h3F800000, 5'b0}) begin
      failures++; $display("FAIL single_head got=%h want=%h", dut_head, {32'h3F800000, 5'b0});
    end
    drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, acc);
    checks++;
    if (dut_state !== exp_state()) begin
      failures++; $display("FAIL single_drain got=%h want=%h", dut_state, exp_state());
    end
  endtask

  task automatic test_fill();
    logic acc;
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 32'(i), 5'(1 << (i - 1)), acc);
    end
    checks++;
    if (dut_state !== {3'd4, 1'b0, 1'b1, 5'd0}) begin
      failures++; $display("FAIL fill_full got=%h want=%h", dut_state, {3'd4, 1'b0, 1'b1, 5'd0});
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd99, 5'd0, acc);
    checks++;
    if (count !== 3'd4 || dut_head !== {32'd1, 5'b00001}) begin
      failures++; $display("FAIL fill_reject count=%0d head=%h want count=4 head=%h", count, dut_head, {32'd1, 5'b00001});
    end
  endtask

  task automatic test_full_drain();
    logic acc;
    logic [31:0] nxt = 32'd5;
    logic [31:0] popped [$];
    for (int i = 0; i < 6; i++) begin
      popped.push_back(out_result);
      drive_cycle(1'b1, 1'b1, 1'b0, nxt, 5'd0, acc);
      if (acc) nxt++;
      if (i == 0) begin
        checks++;
        if (count !== 3'd3) begin
          failures++; $display("FAIL drain_first_no_push got=%0d want=3", count);
        end
      end
      checks++;
      if (dut_state !== exp_state() || dut_head !== mq[0]) begin
        failures++; $display("FAIL drain_cycle%0d state=%h head=%h want state=%h head=%h", i, dut_state, dut_head, exp_state(), mq[0]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (popped[i] !== 32'(i + 1)) begin
        failures++; $display("FAIL drain_order%0d got=%0d want=%0d", i, popped[i], i + 1);
      end
    end
    checks++;
    if (fflags !== 5'b01111) begin
      failures++; $display("FAIL drain_fflags got=%b want=01111", fflags);
    end
  endtask

  task automatic test_clear_pop();
    logic acc;
    while (mq.size() > 0) drive_cycle(1'b0, 1'b1, 1'b0, '0, '0, acc);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'hDEAD0001, 5'b10000, acc);
    checks++;
    if (fflags !== 5'b01111) begin
      failures++; $display("FAIL clr_before got=%b want=01111", fflags);
    end
    drive_cycle(1'b0, 1'b1, 1'b1, '0, '0, acc);
    checks++;
    if (fflags !== 5'b10000 || dut_state !== exp_state()) begin
      failures++; $display("FAIL clr_pop fflags=%b state=%h want fflags=10000 state=%h", fflags, dut_state, exp_state());
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    while (mq.size() < 2) drive_cycle(1'b1, 1'b0, 1'b0, $urandom, 5'($urandom), acc);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, $urandom, 5'($urandom), acc);
      checks++;
      if (count !== 3'd2 || dut_state !== exp_state() || dut_head !== mq[0]) begin
        failures++; $display("FAIL b2b_cycle%0d state=%h head=%h want state=%h head=%h", i, dut_state, dut_head, exp_state(), mq[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    while (mq.size() < 3) drive_cycle(1'b1, 1'b0, 1'b0, $urandom, 5'($urandom), acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    mq.delete(); mf = '0;
    #1;
    checks++;
    if (dut_state !== {3'd0, 1'b1, 1'b0, 5'd0}) begin
      failures++; $display("FAIL async_reset got=%h want=%h", dut_state, {3'd0, 1'b1, 1'b0, 5'd0});
    end
    rst_n = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h12345678, 5'b00101, acc);
    checks++;
    if (dut_state !== {3'd1, 1'b1, 1'b1, 5'd0} || dut_head !== {32'h12345678, 5'b00101}) begin
      failures++; $display("FAIL post_reset_push state=%h head=%h", dut_state, dut_head);
    end
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 80; i++) begin
      drive_cycle(($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 8) == 0, $urandom, 5'($urandom), acc);
      checks++;
      if (dut_state !== exp_state() || (mq.size() != 0 && dut_head !== mq[0])) begin
        failures++; $display("FAIL random_cycle%0d state=%h head=%h want state=%h", i, dut_state, dut_head, exp_state());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_drain();
    test_clear_pop();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
